// File: rtl/rca_config_pkg.sv
// Shared types and sizing for the RCA configuration bank.
// Field encoding, slot record and the index/write helpers used by rca_config_bank.
package rca_config_pkg;

  localparam int unsigned NUM_RCAS        = 4;
  localparam int unsigned NUM_READ_PORTS  = 5;
  localparam int unsigned NUM_WRITE_PORTS = 2;
  localparam int unsigned NUM_IO_UNITS    = 8;
  localparam int unsigned XLEN            = 32;
  localparam int unsigned MAX_INFLIGHT    = 7;

  localparam int unsigned RCA_W = $clog2(NUM_RCAS);
  localparam int unsigned MAX_SLOTS =
      (NUM_READ_PORTS > NUM_WRITE_PORTS) ?
      ((NUM_READ_PORTS > NUM_IO_UNITS) ? NUM_READ_PORTS : NUM_IO_UNITS) :
      ((NUM_WRITE_PORTS > NUM_IO_UNITS) ? NUM_WRITE_PORTS : NUM_IO_UNITS);
  localparam int unsigned CFG_IDX_W = $clog2(MAX_SLOTS);

  typedef enum logic [1:0] {
    FieldSrc   = 2'd0,
    FieldDest  = 2'd1,
    FieldConst = 2'd2
  } rca_cfg_field_t;

  typedef struct packed {
    logic [NUM_IO_UNITS-1:0][XLEN-1:0]  consts;
    logic [NUM_WRITE_PORTS-1:0][4:0]    dest;
    logic [NUM_READ_PORTS-1:0][4:0]     src;
  } rca_slot_cfg_t;

  function automatic logic slot_idx_ok(rca_cfg_field_t field, logic [CFG_IDX_W-1:0] idx);
    logic ok;
    ok = 1'b0;
    case (field)
      FieldSrc:   ok = 32'(idx) < NUM_READ_PORTS;
      FieldDest:  ok = 32'(idx) < NUM_WRITE_PORTS;
      FieldConst: ok = 32'(idx) < NUM_IO_UNITS;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Returns the slot record with one field entry replaced; caller checks the index first.
  function automatic rca_slot_cfg_t slot_write(rca_slot_cfg_t slot, rca_cfg_field_t field,
                                               logic [CFG_IDX_W-1:0] idx,
                                               logic [XLEN-1:0] data);
    rca_slot_cfg_t res;
    res = slot;
    for (int i = 0; i < NUM_READ_PORTS; i++) begin
      if (field == FieldSrc && idx == CFG_IDX_W'(i)) res.src[i] = data[4:0];
    end
    for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
      if (field == FieldDest && idx == CFG_IDX_W'(i)) res.dest[i] = data[4:0];
    end
    for (int i = 0; i < NUM_IO_UNITS; i++) begin
      if (field == FieldConst && idx == CFG_IDX_W'(i)) res.consts[i] = data;
    end
    return res;
  endfunction

endpackage

// File: rtl/rca_inflight_counter.sv
// Saturating up/down count of outstanding uses for a single RCA.
// Simultaneous inc and dec leave the count unchanged.
module rca_inflight_counter #(
  parameter int unsigned MAX_COUNT = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  output logic is_zero,
  output logic is_full
);

  localparam int unsigned CW = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign is_zero = cnt_q == '0;
  assign is_full = cnt_q == CW'(MAX_COUNT);

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec && !is_full) begin
      cnt_d = cnt_q + CW'(1);
    end else if (dec && !inc && !is_zero) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rca_config_bank.sv
// Per-RCA source/destination/constant configuration store with drain-then-commit reconfig.
// RCA_CONFIG_SHADOW_EN: writes land in a shadow bank copied to active on commit; else direct.
module rca_config_bank
  import rca_config_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [RCA_W-1:0]              cfg_rca,
  input  rca_cfg_field_t                cfg_field,
  input  logic [CFG_IDX_W-1:0]          cfg_idx,
  input  logic [XLEN-1:0]               cfg_data,
  output logic                          cfg_err,
  input  logic                          commit_valid,
  output logic                          commit_ready,
  input  logic [RCA_W-1:0]              commit_rca,
  output logic                          commit_done,
  input  logic [RCA_W-1:0]              lookup_rca,
  output logic [5*NUM_READ_PORTS-1:0]   lookup_src,
  output logic [5*NUM_WRITE_PORTS-1:0]  lookup_dest,
  output logic [XLEN*NUM_IO_UNITS-1:0]  lookup_const,
  input  logic                          use_issue,
  input  logic [RCA_W-1:0]              use_issue_rca,
  input  logic                          use_complete,
  input  logic [RCA_W-1:0]              use_complete_rca,
  output logic [NUM_RCAS-1:0]           use_ready
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StDrain = 2'd1;
  localparam logic [1:0] StCopy  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [RCA_W-1:0] target_q, target_d;
  logic             cfg_err_q;
  rca_slot_cfg_t    active_q [NUM_RCAS];
  rca_slot_cfg_t    lookup_q;

  logic                cfg_fire;
  logic                cfg_idx_ok;
  logic [NUM_RCAS-1:0] cnt_zero, cnt_full, use_inc, use_dec;

  assign cfg_ready    = !(state_q == StCopy && cfg_rca == target_q);
  assign cfg_fire     = cfg_valid && cfg_ready;
  assign cfg_idx_ok   = slot_idx_ok(cfg_field, cfg_idx);
  assign commit_ready = state_q == StIdle;
  assign commit_done  = state_q == StDone;
  assign cfg_err      = cfg_err_q;

  assign lookup_src   = lookup_q.src;
  assign lookup_dest  = lookup_q.dest;
  assign lookup_const = lookup_q.consts;

  // The commit target stays blocked from DRAIN until the FSM returns to IDLE.
  always_comb begin
    use_ready = '0;
    use_inc   = '0;
    use_dec   = '0;
    for (int r = 0; r < NUM_RCAS; r++) begin
      use_ready[r] = !cnt_full[r] && !(state_q != StIdle && target_q == RCA_W'(r));
      use_inc[r]   = use_issue && use_issue_rca == RCA_W'(r) && use_ready[r];
      use_dec[r]   = use_complete && use_complete_rca == RCA_W'(r);
    end
  end

  for (genvar r = 0; r < NUM_RCAS; r++) begin : g_cnt
    rca_inflight_counter #(
      .MAX_COUNT (MAX_INFLIGHT)
    ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .inc     (use_inc[r]),
      .dec     (use_dec[r]),
      .is_zero (cnt_zero[r]),
      .is_full (cnt_full[r])
    );
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      StIdle: begin
        if (commit_valid) begin
          state_d  = StDrain;
          target_d = commit_rca;
        end
      end
      StDrain: if (cnt_zero[target_q]) state_d = StCopy;
      StCopy:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      target_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      if (cfg_fire && !cfg_idx_ok) cfg_err_q <= 1'b1;
    end
  end

`ifdef RCA_CONFIG_SHADOW_EN
  rca_slot_cfg_t shadow_q [NUM_RCAS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) shadow_q[r] <= '0;
    end else if (cfg_fire && cfg_idx_ok) begin
      shadow_q[cfg_rca] <= slot_write(shadow_q[cfg_rca], cfg_field, cfg_idx, cfg_data);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) active_q[r] <= '0;
    end else if (state_q == StCopy) begin
      active_q[target_q] <= shadow_q[target_q];
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_RCAS; r++) active_q[r] <= '0;
    end else if (cfg_fire && cfg_idx_ok) begin
      active_q[cfg_rca] <= slot_write(active_q[cfg_rca], cfg_field, cfg_idx, cfg_data);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lookup_q <= '0;
    end else begin
      lookup_q <= active_q[lookup_rca];
    end
  end

endmodule

// File: tb/tb_rca_config_bank.sv
// Bench for rca_config_bank: directed scenarios then random traffic against a behavioural model.
// Model follows RCA_CONFIG_SHADOW_EN the same way the design does.
module tb_rca_config_bank;
  import rca_config_pkg::*;

`ifdef RCA_CONFIG_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                          clk = 1'b0;
  logic                          rst;
  logic                          cfg_valid;
  logic                          cfg_ready;
  logic [RCA_W-1:0]              cfg_rca;
  rca_cfg_field_t                cfg_field;
  logic [CFG_IDX_W-1:0]          cfg_idx;
  logic [XLEN-1:0]               cfg_data;
  logic                          cfg_err;
  logic                          commit_valid;
  logic                          commit_ready;
  logic [RCA_W-1:0]              commit_rca;
  logic                          commit_done;
  logic [RCA_W-1:0]              lookup_rca;
  logic [5*NUM_READ_PORTS-1:0]   lookup_src;
  logic [5*NUM_WRITE_PORTS-1:0]  lookup_dest;
  logic [XLEN*NUM_IO_UNITS-1:0]  lookup_const;
  logic                          use_issue;
  logic [RCA_W-1:0]              use_issue_rca;
  logic                          use_complete;
  logic [RCA_W-1:0]              use_complete_rca;
  logic [NUM_RCAS-1:0]           use_ready;

  always #5 clk = ~clk;

  rca_config_bank dut (
    .clk              (clk),
    .rst              (rst),
    .cfg_valid        (cfg_valid),
    .cfg_ready        (cfg_ready),
    .cfg_rca          (cfg_rca),
    .cfg_field        (cfg_field),
    .cfg_idx          (cfg_idx),
    .cfg_data         (cfg_data),
    .cfg_err          (cfg_err),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_rca       (commit_rca),
    .commit_done      (commit_done),
    .lookup_rca       (lookup_rca),
    .lookup_src       (lookup_src),
    .lookup_dest      (lookup_dest),
    .lookup_const     (lookup_const),
    .use_issue        (use_issue),
    .use_issue_rca    (use_issue_rca),
    .use_complete     (use_complete),
    .use_complete_rca (use_complete_rca),
    .use_ready        (use_ready)
  );

  // Reference model: active/shadow tables, per-RCA use counts, commit phase.
  logic [4:0]      act_src [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]      act_dst [NUM_RCAS][NUM_WRITE_PORTS];
  logic [XLEN-1:0] act_cst [NUM_RCAS][NUM_IO_UNITS];
  logic [4:0]      sh_src  [NUM_RCAS][NUM_READ_PORTS];
  logic [4:0]      sh_dst  [NUM_RCAS][NUM_WRITE_PORTS];
  logic [XLEN-1:0] sh_cst  [NUM_RCAS][NUM_IO_UNITS];
  logic [4:0]      lk_src  [NUM_READ_PORTS];
  logic [4:0]      lk_dst  [NUM_WRITE_PORTS];
  logic [XLEN-1:0] lk_cst  [NUM_IO_UNITS];
  int cnt [NUM_RCAS];
  int phase;   // 0 idle, 1 drain, 2 copy, 3 done
  int target;
  bit err;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int slot_count(rca_cfg_field_t f);
    case (f)
      FieldSrc:   return NUM_READ_PORTS;
      FieldDest:  return NUM_WRITE_PORTS;
      FieldConst: return NUM_IO_UNITS;
      default:    return 0;
    endcase
  endfunction

  function automatic bit m_use_ready(int r);
    return (cnt[r] < MAX_INFLIGHT) && !(phase != 0 && target == r);
  endfunction

  function automatic bit m_cfg_ready();
    return !(phase == 2 && target == int'(cfg_rca));
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NUM_RCAS; r++) begin
      for (int i = 0; i < NUM_READ_PORTS; i++) begin act_src[r][i] = '0; sh_src[r][i] = '0; end
      for (int i = 0; i < NUM_WRITE_PORTS; i++) begin act_dst[r][i] = '0; sh_dst[r][i] = '0; end
      for (int i = 0; i < NUM_IO_UNITS; i++) begin act_cst[r][i] = '0; sh_cst[r][i] = '0; end
      cnt[r] = 0;
    end
    for (int i = 0; i < NUM_READ_PORTS; i++) lk_src[i] = '0;
    for (int i = 0; i < NUM_WRITE_PORTS; i++) lk_dst[i] = '0;
    for (int i = 0; i < NUM_IO_UNITS; i++) lk_cst[i] = '0;
    phase  = 0;
    target = 0;
    err    = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit rdy [NUM_RCAS];
    bit crdy, iss;
    int rc, ix;
    if (rst) begin
      model_reset();
    end else begin
      for (int r = 0; r < NUM_RCAS; r++) rdy[r] = m_use_ready(r);
      crdy = m_cfg_ready();
      rc = int'(lookup_rca);
      for (int i = 0; i < NUM_READ_PORTS; i++) lk_src[i] = act_src[rc][i];
      for (int i = 0; i < NUM_WRITE_PORTS; i++) lk_dst[i] = act_dst[rc][i];
      for (int i = 0; i < NUM_IO_UNITS; i++) lk_cst[i] = act_cst[rc][i];
      if (cfg_valid && crdy) begin
        rc = int'(cfg_rca);
        ix = int'(cfg_idx);
        if (ix >= slot_count(cfg_field)) begin
          err = 1'b1;
        end else begin
          case (cfg_field)
            FieldSrc:  if (SHADOW) sh_src[rc][ix] = cfg_data[4:0];
                       else act_src[rc][ix] = cfg_data[4:0];
            FieldDest: if (SHADOW) sh_dst[rc][ix] = cfg_data[4:0];
                       else act_dst[rc][ix] = cfg_data[4:0];
            default:   if (SHADOW) sh_cst[rc][ix] = cfg_data;
                       else act_cst[rc][ix] = cfg_data;
          endcase
        end
      end
      case (phase)
        0: if (commit_valid) begin phase = 1; target = int'(commit_rca); end
        1: if (cnt[target] == 0) phase = 2;
        2: begin
          if (SHADOW) begin
            for (int i = 0; i < NUM_READ_PORTS; i++) act_src[target][i] = sh_src[target][i];
            for (int i = 0; i < NUM_WRITE_PORTS; i++) act_dst[target][i] = sh_dst[target][i];
            for (int i = 0; i < NUM_IO_UNITS; i++) act_cst[target][i] = sh_cst[target][i];
          end
          phase = 3;
        end
        default: phase = 0;
      endcase
      iss = use_issue && rdy[int'(use_issue_rca)];
      if (!(iss && use_complete && use_issue_rca == use_complete_rca)) begin
        if (iss) cnt[int'(use_issue_rca)]++;
        if (use_complete && cnt[int'(use_complete_rca)] > 0) cnt[int'(use_complete_rca)]--;
      end
    end
  endtask

  task automatic check_outputs();
    logic [5*NUM_READ_PORTS-1:0]  es;
    logic [5*NUM_WRITE_PORTS-1:0] ed;
    logic [XLEN*NUM_IO_UNITS-1:0] ec;
    logic [NUM_RCAS-1:0]          eu;
    for (int i = 0; i < NUM_READ_PORTS; i++) es[5*i +: 5] = lk_src[i];
    for (int i = 0; i < NUM_WRITE_PORTS; i++) ed[5*i +: 5] = lk_dst[i];
    for (int i = 0; i < NUM_IO_UNITS; i++) ec[XLEN*i +: XLEN] = lk_cst[i];
    for (int r = 0; r < NUM_RCAS; r++) eu[r] = m_use_ready(r);
    check("cfg_ready", cfg_ready, m_cfg_ready());
    check("commit_ready", commit_ready, phase == 0);
    check("commit_done", commit_done, phase == 3);
    check("cfg_err", cfg_err, err);
    check("use_ready", use_ready, eu);
    check("lookup_src", lookup_src, es);
    check("lookup_dest", lookup_dest, ed);
    check("lookup_const", lookup_const, ec);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_inputs();
    cfg_valid    = 1'b0;
    commit_valid = 1'b0;
    use_issue    = 1'b0;
    use_complete = 1'b0;
  endtask

  task automatic cfg_write(input int rca, input rca_cfg_field_t f, input int idx,
                           input logic [XLEN-1:0] data);
    cfg_valid = 1'b1;
    cfg_rca   = RCA_W'(rca);
    cfg_field = f;
    cfg_idx   = CFG_IDX_W'(idx);
    cfg_data  = data;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic commit(input int rca);
    commit_valid = 1'b1;
    commit_rca   = RCA_W'(rca);
    step();
    commit_valid = 1'b0;
  endtask

  task automatic use_op(input bit is_issue, input bit is_complete, input int rca);
    use_issue        = is_issue;
    use_issue_rca    = RCA_W'(rca);
    use_complete     = is_complete;
    use_complete_rca = RCA_W'(rca);
    step();
    use_issue    = 1'b0;
    use_complete = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    cfg_rca = '0; cfg_field = FieldSrc; cfg_idx = '0; cfg_data = '0;
    commit_rca = '0; lookup_rca = '0; use_issue_rca = '0; use_complete_rca = '0;
    model_reset();
    step();
    step();
    rst = 1'b0;
    step();

    // Source slot 2 of RCA1, commit with nothing in flight.
    lookup_rca = 2'd1;
    cfg_write(1, FieldSrc, 2, 32'd7);
    commit(1);
    step();
    step();
    check("tp1_done", commit_done, 1'b1);
    step();
    check("tp1_src2", lookup_src[14:10], 5'd7);
    lookup_rca = 2'd0;
    step();
    check("tp1_rca0", lookup_src, '0);

    // Drain of RCA3 with two uses in flight.
    use_op(1, 0, 3);
    use_op(1, 0, 3);
    commit(3);
    repeat (3) step();
    check("tp2_blocked", use_ready[3], 1'b0);
    check("tp2_draining", commit_ready, 1'b0);
    use_op(0, 1, 3);
    use_op(0, 1, 3);
    step();
    step();
    check("tp2_done", commit_done, 1'b1);
    step();

    // Paired issue/complete, then saturation of RCA0.
    repeat (5) use_op(1, 1, 0);
    check("tp3_paired", use_ready[0], 1'b1);
    repeat (7) use_op(1, 0, 0);
    check("tp3_full", use_ready[0], 1'b0);
    use_op(1, 0, 0);
    repeat (7) use_op(0, 1, 0);
    commit(0);
    repeat (4) step();
    check("tp3_back_idle", commit_ready, 1'b1);

    // Out-of-range destination index.
    lookup_rca = 2'd2;
    cfg_write(2, FieldDest, 5, 32'h1f);
    check("tp4_err", cfg_err, 1'b1);
    repeat (2) step();
    check("tp4_dest", lookup_dest, '0);

    // Reset in the middle of a drain.
    use_op(1, 0, 2);
    commit(2);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("tp5_commit_ready", commit_ready, 1'b1);
    check("tp5_err_clr", cfg_err, 1'b0);
    check("tp5_use_ready", use_ready, {NUM_RCAS{1'b1}});

    // Constant write then lookup one cycle later.
    lookup_rca = 2'd3;
    cfg_write(3, FieldConst, 6, 32'hcafe_f00d);
    step();
`ifndef RCA_CONFIG_SHADOW_EN
    check("tp6_const", lookup_const[6*XLEN +: XLEN], 32'hcafe_f00d);
`endif

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      rst              = ($urandom_range(0, 399) == 0);
      cfg_valid        = ($urandom_range(0, 9) < 3);
      cfg_rca          = RCA_W'($urandom_range(0, NUM_RCAS - 1));
      cfg_field        = rca_cfg_field_t'($urandom_range(0, 2));
      cfg_idx          = CFG_IDX_W'($urandom_range(0, MAX_SLOTS - 1));
      cfg_data         = $urandom;
      commit_valid     = ($urandom_range(0, 9) == 0);
      commit_rca       = RCA_W'($urandom_range(0, NUM_RCAS - 1));
      lookup_rca       = RCA_W'($urandom_range(0, NUM_RCAS - 1));
      use_issue        = ($urandom_range(0, 9) < 4);
      use_issue_rca    = RCA_W'($urandom_range(0, NUM_RCAS - 1));
      use_complete     = ($urandom_range(0, 9) < 4);
      use_complete_rca = RCA_W'($urandom_range(0, NUM_RCAS - 1));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
